// File: rtl/vc_input_queue.sv
// Multi-virtual-channel router input buffer: VC independent circular FIFOs
// with a round-robin arbiter presenting one head packet per cycle.
module vc_input_queue #(
    parameter int unsigned PL    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VC    = 2,
    localparam int unsigned VCW  = (VC > 1) ? $clog2(VC) : 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [VCW-1:0]   in_vc,
    input  logic [PL-1:0]    in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [VCW-1:0]   out_vc,
    output logic [PL-1:0]    out_data,
    input  logic             out_ready,
    output logic [VC-1:0]    vc_full,
    output logic [VC-1:0]    vc_empty,
    output logic [VC*CW-1:0] vc_count,
    output logic             push_err
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PL-1:0]  mem    [VC][DEPTH];
    logic [PW-1:0]  wr_ptr [VC];
    logic [PW-1:0]  rd_ptr [VC];
    logic [CW-1:0]  cnt    [VC];
    logic [VCW-1:0] rr_ptr;

    logic [VC-1:0]  sel;
    logic           in_vc_ok;
    logic [VCW-1:0] grant;
    logic           any;
    logic           push;
    logic           pop;

    // Per-channel status and input channel decode
    always_comb begin
        vc_full  = '0;
        vc_empty = '0;
        vc_count = '0;
        sel      = '0;
        for (int unsigned i = 0; i < VC; i++) begin
            vc_full[i]            = (cnt[i] == CW'(DEPTH));
            vc_empty[i]           = (cnt[i] == '0);
            vc_count[i*CW +: CW]  = cnt[i];
            sel[i]                = (VC == 1) ? 1'b1 : (in_vc == VCW'(i));
        end
    end

    // Out-of-range channel indices are refused; readiness ignores out_ready
    assign in_vc_ok = (VC == 1) || (32'(in_vc) < VC);
    assign in_ready = in_vc_ok && |(sel & ~vc_full);
    assign push     = in_valid && in_ready;

    // Round-robin grant: first non-empty channel at or after rr_ptr
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < VC; k++) begin
            for (int unsigned i = 0; i < VC; i++) begin
                if (!any && i == (32'(rr_ptr) + k) % VC && cnt[i] != '0) begin
                    grant = VCW'(i);
                    any   = 1'b1;
                end
            end
        end
    end

    assign out_valid = any;
    assign out_vc    = any ? grant : '0;
    assign pop       = any && out_ready;

    // Head of the granted channel, forced to zero when nothing is presented
    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < VC; i++) begin
            if (any && grant == VCW'(i)) out_data = mem[i][rd_ptr[i]];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < VC; i++) begin
            if (push && sel[i]) mem[i][wr_ptr[i]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < VC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            rr_ptr   <= '0;
            push_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < VC; i++) begin
                if (push && sel[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop && grant == VCW'(i)) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                cnt[i] <= cnt[i] + CW'(push && sel[i]) - CW'(pop && grant == VCW'(i));
            end
            if (pop) rr_ptr <= (32'(grant) == VC - 1) ? '0 : grant + 1'b1;
            if (in_valid && !in_ready) push_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_input_queue.sv
// Scoreboard bench for vc_input_queue (PL=8, DEPTH=4, VC=2): directed pushes
// queue expected {vc,data}; a negedge monitor checks every accepted pop.
module tb_vc_input_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [0:0] in_vc;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [0:0] out_vc;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] vc_full;
    logic [1:0] vc_empty;
    logic [5:0] vc_count;
    logic       push_err;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    vc_input_queue #(.PL(8), .DEPTH(4), .VC(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_vc(out_vc), .out_data(out_data), .out_ready(out_ready),
        .vc_full(vc_full), .vc_empty(vc_empty), .vc_count(vc_count), .push_err(push_err)
    );

    always #5 clk = ~clk;

    // Monitor: every presented-and-consumed packet must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pop got vc=%0d data=%h, required none", out_vc, out_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({out_vc, out_data} !== e) begin
                    n_err++;
                    $display("FAIL pop got vc=%0d data=%h, required vc=%0d data=%h",
                             out_vc, out_data, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push(input logic vc, input logic [7:0] d);
        in_valid = 1'b1;
        in_vc    = vc;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_pop(input logic vc, input logic [7:0] d);
        exp_q.push_back({vc, d});
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) step();
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vc = '0; in_data = '0; out_ready = 1'b0;
        step();
        // Reset then idle
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h00);
        check("rst_vc_empty",  32'(vc_empty),  32'b11);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        step();
        check("idle_vc_full",  32'(vc_full),   32'b00);
        check("idle_vc_count", 32'(vc_count),  32'd0);
        check("idle_push_err", 32'(push_err),  32'd0);

        // Fill VC0, overflow, drain in order
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 8'h80 + 8'(i));
            expect_pop(1'b0, 8'h80 + 8'(i));
        end
        check("fill_vc_full",   32'(vc_full),        32'b01);
        check("fill_count_vc0", 32'(vc_count[2:0]),  32'd4);
        in_valid = 1'b1; in_vc = 1'b0; in_data = 8'h84;
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        check("ovf_push_err",  32'(push_err),       32'd1);
        check("ovf_count_vc0", 32'(vc_count[2:0]),  32'd4);
        drain(4);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_out_data",  32'(out_data),  32'h00);

        // Round-robin alternation from a fresh rr_ptr
        pulse_reset();
        check("rr_push_err_clr", 32'(push_err), 32'd0);
        push(1'b0, 8'hA0); push(1'b0, 8'hA1);
        push(1'b1, 8'hB0); push(1'b1, 8'hB1);
        expect_pop(1'b0, 8'hA0); expect_pop(1'b1, 8'hB0);
        expect_pop(1'b0, 8'hA1); expect_pop(1'b1, 8'hB1);
        drain(4);
        check("rr_empty", 32'(vc_empty), 32'b11);

        // Pointer wrap on VC1
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 8'h10 + 8'(i));
            expect_pop(1'b1, 8'h10 + 8'(i));
        end
        drain(3);
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 8'h90 + 8'(i));
            expect_pop(1'b1, 8'h90 + 8'(i));
        end
        check("wrap_vc_full",   32'(vc_full),       32'b10);
        check("wrap_count_vc1", 32'(vc_count[5:3]), 32'd4);
        drain(4);
        check("wrap_drained", 32'(out_valid), 32'd0);

        // Simultaneous push and pop on VC0 holding two packets
        push(1'b0, 8'hD0); push(1'b0, 8'hD1);
        expect_pop(1'b0, 8'hD0); expect_pop(1'b0, 8'hD1); expect_pop(1'b0, 8'hC5);
        in_valid = 1'b1; in_vc = 1'b0; in_data = 8'hC5; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("sim_count_vc0", 32'(vc_count[2:0]), 32'd2);
        drain(2);
        check("sim_empty", 32'(vc_empty), 32'b11);

        // Asynchronous reset between edges with both channels loaded
        push(1'b0, 8'h11); push(1'b0, 8'h12);
        for (int i = 0; i < 4; i++) push(1'b1, 8'h21 + 8'(i));
        push(1'b1, 8'h25);
        check("pre_rst_push_err",  32'(push_err),  32'd1);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data",  32'(out_data),  32'h00);
        check("arst_out_vc",    32'(out_vc),    32'd0);
        check("arst_vc_empty",  32'(vc_empty),  32'b11);
        check("arst_vc_full",   32'(vc_full),   32'b00);
        check("arst_vc_count",  32'(vc_count),  32'd0);
        check("arst_push_err",  32'(push_err),  32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        step();
        rst = 1'b0;
        step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
